// File: rtl/soc_bus_pkg.sv
// Shared types and constants for the SoC data-bus router.
//   state_t    : router FSM states
//   bus_req_t  : latched master request broadcast to the slaves
//   BUS_AW/BUS_DW/REGION_W/STRB_W : bus geometry
//   REGION_*   : default region IDs of the memory, GPIO and UART slaves
package soc_bus_pkg;

    localparam int unsigned BUS_AW   = 32;
    localparam int unsigned BUS_DW   = 32;
    localparam int unsigned REGION_W = 4;
    localparam int unsigned STRB_W   = BUS_DW / 8;

    localparam logic [REGION_W-1:0] REGION_MEM  = 4'h0;
    localparam logic [REGION_W-1:0] REGION_GPIO = 4'h4;
    localparam logic [REGION_W-1:0] REGION_UART = 4'h5;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    typedef struct packed {
        logic              we;
        logic [BUS_AW-1:0] addr;
        logic [BUS_DW-1:0] wdata;
        logic [STRB_W-1:0] wstrb;
    } bus_req_t;

endpackage

// File: rtl/bus_addr_router_if.sv
// Bus bundle between one master, the router and N_SLAVES slaves.
//   m_*    : master request (valid/we/addr/wdata/wstrb) and response (ready/rdata/err)
//   s_*    : one-hot slave request, broadcast request payload, slave ready/rdata
// Modports: master (CPU side), slave (peripheral side), router (the routing block).
interface bus_addr_router_if #(
    parameter int unsigned N_SLAVES = 3
);
    import soc_bus_pkg::*;

    logic                       m_valid;
    logic                       m_we;
    logic [BUS_AW-1:0]          m_addr;
    logic [BUS_DW-1:0]          m_wdata;
    logic [STRB_W-1:0]          m_wstrb;
    logic                       m_ready;
    logic [BUS_DW-1:0]          m_rdata;
    logic                       m_err;

    logic [N_SLAVES-1:0]        s_valid;
    logic                       s_we;
    logic [BUS_AW-1:0]          s_addr;
    logic [BUS_DW-1:0]          s_wdata;
    logic [STRB_W-1:0]          s_wstrb;
    logic [N_SLAVES-1:0]        s_ready;
    logic [BUS_DW*N_SLAVES-1:0] s_rdata;

    modport master (
        output m_valid, m_we, m_addr, m_wdata, m_wstrb,
        input  m_ready, m_rdata, m_err
    );

    modport slave (
        input  s_valid, s_we, s_addr, s_wdata, s_wstrb,
        output s_ready, s_rdata
    );

    modport router (
        input  m_valid, m_we, m_addr, m_wdata, m_wstrb, s_ready, s_rdata,
        output m_ready, m_rdata, m_err, s_valid, s_we, s_addr, s_wdata, s_wstrb
    );

endinterface

// File: rtl/bus_region_match.sv
// Combinational region decoder: compares an address nibble against the
// per-slave region table; the lowest matching slave index wins.
//   i_region : addr[31:28] of the request
//   o_hit    : some slave owns the region
//   o_idx    : binary index of the owning slave (0 when no hit)
module bus_region_match
    import soc_bus_pkg::*;
#(
    parameter int unsigned                  N_SLAVES   = 3,
    parameter int unsigned                  IDX_W      = 2,
    parameter logic [REGION_W*N_SLAVES-1:0] REGION_MAP = {REGION_UART, REGION_GPIO, REGION_MEM}
) (
    input  logic [REGION_W-1:0] i_region,
    output logic                o_hit,
    output logic [IDX_W-1:0]    o_idx
);

    // Scan from the top down so a lower-indexed match overwrites a higher one.
    always_comb begin
        o_hit = 1'b0;
        o_idx = '0;
        for (int i = int'(N_SLAVES) - 1; i >= 0; i--) begin
            if (REGION_MAP[REGION_W*i +: REGION_W] == i_region) begin
                o_hit = 1'b1;
                o_idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/bus_addr_router.sv
// Single-master to N_SLAVES-slave data-bus router.
// Decodes addr[31:28], registers the request to the owning slave, waits for
// that slave's ready and returns its read data as a one-cycle m_ready pulse.
// Unmapped regions get an immediate error response.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : bus_addr_router_if.router (master request/response, slave request/ready/rdata)
// Optional: `define BUS_TIMEOUT_EN adds an ACCESS watchdog of TIMEOUT_CYCLES cycles
// that ends a stalled access with an error response.
module bus_addr_router
    import soc_bus_pkg::*;
#(
    parameter int unsigned                  N_SLAVES       = 3,
    parameter logic [REGION_W*N_SLAVES-1:0] REGION_MAP     = {REGION_UART, REGION_GPIO, REGION_MEM},
    parameter int unsigned                  TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    bus_addr_router_if.router bus
);

    localparam int unsigned IDX_W = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;

    state_t              r_state,   w_state_nxt;
    bus_req_t            r_req,     w_req_nxt;
    logic [N_SLAVES-1:0] r_s_valid, w_s_valid_nxt;
    logic                r_m_ready, w_m_ready_nxt;
    logic                r_m_err,   w_m_err_nxt;
    logic [BUS_DW-1:0]   r_m_rdata, w_m_rdata_nxt;

    logic                w_hit;
    logic [IDX_W-1:0]    w_idx;
    logic                w_sel_ready;
    logic [BUS_DW-1:0]   w_sel_rdata;
    logic                w_wdog_expired;

    // Region decode of the live master address (only consumed in IDLE).
    bus_region_match #(
        .N_SLAVES   (N_SLAVES),
        .IDX_W      (IDX_W),
        .REGION_MAP (REGION_MAP)
    ) u_match (
        .i_region (bus.m_addr[BUS_AW-1 -: REGION_W]),
        .o_hit    (w_hit),
        .o_idx    (w_idx)
    );

    // s_valid is one-hot during ACCESS, so masking with it honours only the addressed slave.
    assign w_sel_ready = |(bus.s_ready & r_s_valid);

    // Read-data mux selected by the one-hot request.
    always_comb begin
        w_sel_rdata = '0;
        for (int i = 0; i < int'(N_SLAVES); i++) begin
            if (r_s_valid[i]) begin
                w_sel_rdata = w_sel_rdata | bus.s_rdata[BUS_DW*i +: BUS_DW];
            end
        end
    end

`ifdef BUS_TIMEOUT_EN
    localparam int unsigned WDOG_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [WDOG_W-1:0] r_wdog, w_wdog_nxt;

    // Counts completed ACCESS cycles; zero on every entry to ACCESS.
    assign w_wdog_expired = (r_wdog == WDOG_W'(TIMEOUT_CYCLES - 1));
    assign w_wdog_nxt     = (r_state == ST_ACCESS && w_state_nxt == ST_ACCESS)
                          ? r_wdog + WDOG_W'(1) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wdog <= '0;
        end else begin
            r_wdog <= w_wdog_nxt;
        end
    end
`else
    // No watchdog: ACCESS waits for the slave indefinitely.
    assign w_wdog_expired = 1'b0;

    if (TIMEOUT_CYCLES == 0) begin : g_wdog_disabled
    end
`endif

    // Next-state and next-register logic.
    always_comb begin
        w_state_nxt   = r_state;
        w_req_nxt     = r_req;
        w_s_valid_nxt = r_s_valid;
        w_m_ready_nxt = 1'b0;
        w_m_err_nxt   = r_m_err;
        w_m_rdata_nxt = r_m_rdata;

        case (r_state)
            ST_IDLE: begin
                if (bus.m_valid) begin
                    w_req_nxt = '{we: bus.m_we, addr: bus.m_addr,
                                  wdata: bus.m_wdata, wstrb: bus.m_wstrb};
                    if (w_hit) begin
                        w_s_valid_nxt = N_SLAVES'(1) << w_idx;
                        w_state_nxt   = ST_ACCESS;
                    end else begin
                        w_m_ready_nxt = 1'b1;
                        w_m_err_nxt   = 1'b1;
                        w_m_rdata_nxt = '0;
                        w_state_nxt   = ST_RESP;
                    end
                end
            end
            ST_ACCESS: begin
                // A slave completion in the limit cycle still wins over the watchdog.
                if (w_sel_ready) begin
                    w_s_valid_nxt = '0;
                    w_m_ready_nxt = 1'b1;
                    w_m_err_nxt   = 1'b0;
                    w_m_rdata_nxt = r_req.we ? '0 : w_sel_rdata;
                    w_state_nxt   = ST_RESP;
                end else if (w_wdog_expired) begin
                    w_s_valid_nxt = '0;
                    w_m_ready_nxt = 1'b1;
                    w_m_err_nxt   = 1'b1;
                    w_m_rdata_nxt = '0;
                    w_state_nxt   = ST_RESP;
                end
            end
            ST_RESP: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt   = ST_IDLE;
                w_s_valid_nxt = '0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_req     <= '0;
            r_s_valid <= '0;
            r_m_ready <= 1'b0;
            r_m_err   <= 1'b0;
            r_m_rdata <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_req     <= w_req_nxt;
            r_s_valid <= w_s_valid_nxt;
            r_m_ready <= w_m_ready_nxt;
            r_m_err   <= w_m_err_nxt;
            r_m_rdata <= w_m_rdata_nxt;
        end
    end

    assign bus.m_ready = r_m_ready;
    assign bus.m_err   = r_m_err;
    assign bus.m_rdata = r_m_rdata;
    assign bus.s_valid = r_s_valid;
    assign bus.s_we    = r_req.we;
    assign bus.s_addr  = r_req.addr;
    assign bus.s_wdata = r_req.wdata;
    assign bus.s_wstrb = r_req.wstrb;

endmodule

// File: tb/tb_bus_addr_router.sv
// Bench for bus_addr_router: directed vector table, random transactions against
// a region-table reference model, and hand-written reset / timeout / overlap sequences.
module tb_bus_addr_router;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    bus_addr_router_if #(.N_SLAVES(3)) bus  ();
    bus_addr_router_if #(.N_SLAVES(3)) bus2 ();

    bus_addr_router #(
        .N_SLAVES(3), .REGION_MAP(12'h540), .TIMEOUT_CYCLES(8)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    // Overlapping map: slaves 1 and 2 both claim region 4.
    bus_addr_router #(
        .N_SLAVES(3), .REGION_MAP(12'h440), .TIMEOUT_CYCLES(8)
    ) u_dut_dup (
        .clk(clk), .rst_n(rst_n), .bus(bus2)
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          wait_c;
        logic [31:0] rd_val;
        bit          exp_hit;
        int          exp_idx;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    logic [3:0] map_a [3] = '{4'h0, 4'h4, 4'h5};
    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference: owner is the lowest slave whose region equals addr[31:28];
    // hit answers 2+wait cycles after the request, miss answers after 1 cycle.
    function automatic vec_t model(input logic we, input logic [31:0] addr,
                                   input logic [31:0] wdata, input logic [3:0] wstrb,
                                   input int wait_c, input logic [31:0] rd_val);
        vec_t v;
        int   owner = -1;
        for (int i = 2; i >= 0; i--) if (map_a[i] == addr[31:28]) owner = i;
        v.we = we; v.addr = addr; v.wdata = wdata; v.wstrb = wstrb;
        v.wait_c = wait_c; v.rd_val = rd_val;
        v.exp_hit   = (owner >= 0);
        v.exp_idx   = (owner >= 0) ? owner : 0;
        v.exp_err   = (owner < 0);
        v.exp_rdata = (owner >= 0 && !we) ? rd_val : 32'h0;
        v.exp_lat   = (owner >= 0) ? 2 + wait_c : 1;
        return v;
    endfunction

    // Issues one request on bus at a negedge and checks every cycle until the response.
    task automatic run_txn(input vec_t v, input string tag);
        logic [2:0] oh;
        logic [2:0] junk;
        bit         done;
        oh = v.exp_hit ? 3'(3'b001 << v.exp_idx) : 3'b000;
        bus.m_valid = 1'b1;
        bus.m_we    = v.we;
        bus.m_addr  = v.addr;
        bus.m_wdata = v.wdata;
        bus.m_wstrb = v.wstrb;
        for (int i = 0; i < 3; i++)
            bus.s_rdata[32*i +: 32] = (v.exp_hit && i == v.exp_idx) ? v.rd_val : $urandom;
        bus.s_ready = 3'($urandom);
        done = 1'b0;
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            chk({tag, ".s_ctl"},   64'({bus.s_we, bus.s_wstrb}), 64'({v.we, v.wstrb}));
            chk({tag, ".s_addr"},  64'(bus.s_addr),  64'(v.addr));
            chk({tag, ".s_wdata"}, 64'(bus.s_wdata), 64'(v.wdata));
            if (bus.m_ready === 1'b1) begin
                chk({tag, ".lat"},    64'(c),           64'(v.exp_lat));
                chk({tag, ".rdata"},  64'(bus.m_rdata), 64'(v.exp_rdata));
                chk({tag, ".err"},    64'(bus.m_err),   64'(v.exp_err));
                chk({tag, ".sv_end"}, 64'(bus.s_valid), 64'(0));
                done = 1'b1;
                break;
            end
            chk({tag, ".s_valid"}, 64'(bus.s_valid), 64'(oh));
            // Master keeps m_valid but its payload must no longer matter.
            bus.m_we    = 1'($urandom);
            bus.m_addr  = $urandom;
            bus.m_wdata = $urandom;
            bus.m_wstrb = 4'($urandom);
            junk = 3'($urandom) & ~oh;
            bus.s_ready = (v.exp_hit && c == 1 + v.wait_c) ? (junk | oh) : junk;
        end
        if (!done) begin
            n_chk++;
            $display("FAIL %s.no_resp: m_ready not seen in 16 cycles, expected at cycle %0d",
                     tag, v.exp_lat);
        end
        bus.m_valid = 1'b0;
        bus.s_ready = 3'($urandom);
        @(negedge clk);
        chk({tag, ".idle"},       64'({bus.m_ready, bus.s_valid}), 64'(0));
        chk({tag, ".hold_rdata"}, 64'(bus.m_rdata), 64'(v.exp_rdata));
        chk({tag, ".hold_err"},   64'(bus.m_err),   64'(v.exp_err));
    endtask

    vec_t tbl [7];
    vec_t rv;
    int   seen;

    initial begin
        tbl = '{
            '{1'b0, 32'h4000_0010, 32'h0000_0000, 4'hF,    0, 32'hDEAD_BEEF, 1'b1, 1, 32'hDEAD_BEEF, 1'b0, 2},
            '{1'b1, 32'h5000_0004, 32'hCAFE_F00D, 4'b0011, 5, 32'h7777_7777, 1'b1, 2, 32'h0000_0000, 1'b0, 7},
            '{1'b0, 32'h7000_0000, 32'h0000_0000, 4'hF,    0, 32'h1357_9BDF, 1'b0, 0, 32'h0000_0000, 1'b1, 1},
            '{1'b0, 32'h0000_1234, 32'h0000_0000, 4'hF,    2, 32'h1234_5678, 1'b1, 0, 32'h1234_5678, 1'b0, 4},
            '{1'b1, 32'hF000_0000, 32'hFFFF_FFFF, 4'hF,    0, 32'h0000_0000, 1'b0, 0, 32'h0000_0000, 1'b1, 1},
            '{1'b1, 32'h0000_0000, 32'h0BAD_F00D, 4'hF,    0, 32'h5555_AAAA, 1'b1, 0, 32'h0000_0000, 1'b0, 2},
            '{1'b0, 32'h5FFF_FFFC, 32'h0000_0000, 4'hF,    1, 32'hA5A5_0F0F, 1'b1, 2, 32'hA5A5_0F0F, 1'b0, 3}
        };

        rst_n = 1'b0;
        bus.m_valid = 1'b0;  bus.m_we = 1'b0;  bus.m_addr = '0;  bus.m_wdata = '0;
        bus.m_wstrb = '0;    bus.s_ready = '0; bus.s_rdata = '0;
        bus2.m_valid = 1'b0; bus2.m_we = 1'b0; bus2.m_addr = '0; bus2.m_wdata = '0;
        bus2.m_wstrb = '0;   bus2.s_ready = '0; bus2.s_rdata = '0;

        repeat (2) @(negedge clk);
        chk("reset.ctl",   64'({bus.m_ready, bus.m_err, bus.s_valid, bus.s_we, bus.s_wstrb}), 64'(0));
        chk("reset.rdata", 64'(bus.m_rdata), 64'(0));
        chk("reset.addr",  64'({bus.s_addr, bus.s_wdata}), 64'(0));
        chk("reset.dup",   64'({bus2.m_ready, bus2.s_valid}), 64'(0));
        rst_n = 1'b1;
        @(negedge clk);

        for (int k = 0; k < 7; k++) run_txn(tbl[k], $sformatf("vec%0d", k));

        // Reset while slave 1 is being accessed.
        bus.m_valid = 1'b1; bus.m_we = 1'b0; bus.m_addr = 32'h4000_0010; bus.s_ready = '0;
        @(negedge clk);
        chk("rst_mid.pre_sval", 64'(bus.s_valid), 64'(3'b010));
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_mid.ctl",   64'({bus.m_ready, bus.m_err, bus.s_valid, bus.s_we, bus.s_wstrb}), 64'(0));
        chk("rst_mid.rdata", 64'(bus.m_rdata), 64'(0));
        chk("rst_mid.bus",   64'({bus.s_addr, bus.s_wdata}), 64'(0));
        bus.m_valid = 1'b0;
        bus.s_ready = 3'b010;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("rst_mid.quiet", 64'({bus.m_ready, bus.s_valid}), 64'(0));
        end
        rst_n = 1'b1;
        bus.s_ready = '0;
        @(negedge clk);
        chk("rst_mid.after", 64'({bus.m_ready, bus.s_valid}), 64'(0));

        for (int k = 0; k < 40; k++) begin
            logic [31:0] a;
            a = $urandom;
            case ($urandom_range(0, 4))
                0: a[31:28] = 4'h0;
                1: a[31:28] = 4'h4;
                2: a[31:28] = 4'h5;
                default: ;
            endcase
            rv = model(1'($urandom), a, $urandom, 4'($urandom), $urandom_range(0, 4), $urandom);
            run_txn(rv, $sformatf("rnd%0d", k));
        end

        // Slave 0 never answers.
        bus.m_valid = 1'b1; bus.m_we = 1'b0; bus.m_addr = 32'h0000_0040; bus.s_ready = '0;
        seen = 0;
        for (int c = 1; c <= 1000; c++) begin
            @(negedge clk);
            if (bus.m_ready === 1'b1) begin
                seen = c;
                break;
            end
            bus.s_ready = 3'($urandom) & 3'b110;
        end
`ifdef BUS_TIMEOUT_EN
        chk("tmo.lat",   64'(seen), 64'(9));
        chk("tmo.err",   64'({bus.m_err, bus.s_valid}), 64'({1'b1, 3'b000}));
        chk("tmo.rdata", 64'(bus.m_rdata), 64'(0));
`else
        chk("tmo.none",  64'(seen), 64'(0));
        chk("tmo.sval",  64'(bus.s_valid), 64'(3'b001));
`endif
        bus.m_valid = 1'b0;
        bus.s_ready = '0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Overlapping regions: slave 1 owns 0x4xxx_xxxx, slave 2's strobe is ignored.
        bus2.m_valid = 1'b1; bus2.m_we = 1'b0; bus2.m_addr = 32'h4000_0000;
        bus2.s_rdata = {32'h2222_2222, 32'h1111_1111, 32'h0000_0000};
        @(negedge clk);
        chk("dup.sval0", 64'(bus2.s_valid), 64'(3'b010));
        bus2.s_ready = 3'b100;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("dup.stray", 64'({bus2.m_ready, bus2.s_valid}), 64'({1'b0, 3'b010}));
        end
        bus2.s_ready = 3'b010;
        @(negedge clk);
        chk("dup.ready", 64'({bus2.m_ready, bus2.m_err, bus2.s_valid}), 64'({1'b1, 1'b0, 3'b000}));
        chk("dup.rdata", 64'(bus2.m_rdata), 64'(32'h1111_1111));
        bus2.m_valid = 1'b0;
        bus2.s_ready = '0;
        @(negedge clk);
        // Region 5 is unmapped in this table.
        bus2.m_valid = 1'b1; bus2.m_addr = 32'h5000_0000;
        @(negedge clk);
        chk("dup.miss",  64'({bus2.m_ready, bus2.m_err, bus2.s_valid}), 64'({1'b1, 1'b1, 3'b000}));
        chk("dup.miss_rdata", 64'(bus2.m_rdata), 64'(0));
        bus2.m_valid = 1'b0;
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
